// File: rtl/pid_pkg.sv
// Shared definitions for the PID Wishbone master: register indices, sequencer
// states and the index-to-byte-address mapping.
package pid_pkg;

    localparam logic [3:0] KP_IDX = 4'd0;
    localparam logic [3:0] KI_IDX = 4'd1;
    localparam logic [3:0] KD_IDX = 4'd2;
    localparam logic [3:0] SP_IDX = 4'd3;
    localparam logic [3:0] PV_IDX = 4'd4;
    localparam logic [3:0] UN_IDX = 4'd8;
    localparam logic [3:0] OF_IDX = 4'd10;
    localparam logic [3:0] RS_IDX = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_PV_WR,
        ST_UN_RD,
        ST_OF_RD,
        ST_RS_WR,
        ST_GAP
    } state_t;

    // Registers sit on natural word boundaries of the bus width.
    function automatic logic [31:0] byte_addr(input logic [3:0] idx, input int nb);
        return (nb == 64) ? {25'd0, idx, 3'd0} : {26'd0, idx, 2'd0};
    endfunction

endpackage

// File: rtl/wb_master_port.sv
// Single Wishbone Classic transaction engine: launches on req, finishes on
// ack (done) or after TIMEOUT cycles of stb without ack (timeout).
module wb_master_port #(
    parameter int wb_nb     = 32,
    parameter int adr_wb_nb = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 req_we,
    input  logic [adr_wb_nb-1:0] req_adr,
    input  logic [wb_nb-1:0]     req_data,
    input  logic                 wb_ack,
    input  logic [wb_nb-1:0]     wb_rdata,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [adr_wb_nb-1:0] wb_adr,
    output logic [wb_nb-1:0]     wb_wdata,
    output logic                 done,
    output logic                 timeout,
    output logic [31:0]          rd_data
);

    logic [15:0] wait_cnt;
    logic        unused_rdata;

    assign unused_rdata = ^wb_rdata;

    assign done    = wb_stb & wb_ack;
    assign timeout = wb_stb & ~wb_ack & (wait_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_wdata <= '0;
            wait_cnt <= '0;
            rd_data  <= '0;
        end else if (wb_stb) begin
            if (done || timeout) begin
                wb_cyc   <= 1'b0;
                wb_stb   <= 1'b0;
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (done && !wb_we)
                rd_data <= wb_rdata[31:0];
        end else if (req) begin
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            wb_we    <= req_we;
            wb_adr   <= req_adr;
            wb_wdata <= req_data;
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/pid_wb_master.sv
// Sequencer driving the PID slave: coefficient load, pv write / un read, RS write.
// Optional PID_MASTER_OF_READ_EN adds an overflow-register read and the o_of output.
module pid_wb_master
    import pid_pkg::*;
#(
    parameter int wb_nb     = 32,
    parameter int adr_wb_nb = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cfg_start,
    input  logic signed [15:0]   i_kp,
    input  logic signed [15:0]   i_ki,
    input  logic signed [15:0]   i_kd,
    input  logic signed [15:0]   i_sp,
    input  logic                 i_clear,
    input  logic signed [15:0]   i_pv,
    input  logic                 i_pv_valid,
    output logic                 o_pv_ready,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [adr_wb_nb-1:0] o_wb_adr,
    output logic [wb_nb-1:0]     o_wb_data,
    input  logic                 i_wb_ack,
    input  logic [wb_nb-1:0]     i_wb_data,
    output logic [31:0]          o_un,
    output logic                 o_un_valid,
    output logic                 o_busy,
`ifdef PID_MASTER_OF_READ_EN
    output logic [4:0]           o_of,
`endif
    output logic                 o_err
);

    state_t             state, state_n, nxt, nxt_n;
    logic [1:0]         cfg_cnt, cfg_cnt_n;
    logic               configured, configured_n;
    logic               err_n;
    logic               pub, pub_n;
    logic               load_coef, load_pv;
    logic signed [15:0] coef [4];
    logic signed [15:0] pv_q;
    logic               req, req_we;
    logic [3:0]         req_idx;
    logic signed [15:0] req_val;
    logic [wb_nb-1:0]   req_data;
    logic [adr_wb_nb-1:0] req_adr;
    logic               port_done, port_timeout;
    logic [31:0]        rd_data;
`ifdef PID_MASTER_OF_READ_EN
    logic [31:0]        un_hold;
`endif

    assign req_data = {{(wb_nb-16){req_val[15]}}, req_val};
    assign req_adr  = adr_wb_nb'(byte_addr(req_idx, wb_nb));

    wb_master_port #(
        .wb_nb    (wb_nb),
        .adr_wb_nb(adr_wb_nb),
        .TIMEOUT  (TIMEOUT)
    ) u_port (
        .clk     (i_clk),
        .rst     (i_rst),
        .req     (req),
        .req_we  (req_we),
        .req_adr (req_adr),
        .req_data(req_data),
        .wb_ack  (i_wb_ack),
        .wb_rdata(i_wb_data),
        .wb_cyc  (o_wb_cyc),
        .wb_stb  (o_wb_stb),
        .wb_we   (o_wb_we),
        .wb_adr  (o_wb_adr),
        .wb_wdata(o_wb_data),
        .done    (port_done),
        .timeout (port_timeout),
        .rd_data (rd_data)
    );

    always_comb begin
        state_n      = state;
        nxt_n        = nxt;
        cfg_cnt_n    = cfg_cnt;
        configured_n = configured;
        err_n        = o_err;
        pub_n        = 1'b0;
        load_coef    = 1'b0;
        load_pv      = 1'b0;
        req          = 1'b0;
        req_we       = 1'b0;
        req_idx      = KP_IDX;
        req_val      = '0;
        case (state)
            ST_IDLE: begin
                if (i_clear) begin
                    state_n = ST_RS_WR;
                end else if (i_cfg_start) begin
                    state_n   = ST_CFG;
                    cfg_cnt_n = 2'd0;
                    err_n     = 1'b0;
                    load_coef = 1'b1;
                end else if (i_pv_valid && o_pv_ready) begin
                    state_n = ST_PV_WR;
                    load_pv = 1'b1;
                end
            end
            // Index of kp..sp equals the load counter.
            ST_CFG: begin
                req     = ~o_wb_cyc;
                req_we  = 1'b1;
                req_idx = {2'b00, cfg_cnt};
                req_val = coef[cfg_cnt];
                if (port_done) begin
                    state_n   = ST_GAP;
                    cfg_cnt_n = cfg_cnt + 2'd1;
                    nxt_n     = (cfg_cnt == 2'd3) ? ST_IDLE : ST_CFG;
                    if (cfg_cnt == 2'd3)
                        configured_n = 1'b1;
                end
            end
            ST_PV_WR: begin
                req     = ~o_wb_cyc;
                req_we  = 1'b1;
                req_idx = PV_IDX;
                req_val = pv_q;
                if (port_done) begin
                    state_n = ST_GAP;
                    nxt_n   = ST_UN_RD;
                end
            end
            ST_UN_RD: begin
                req     = ~o_wb_cyc;
                req_idx = UN_IDX;
                if (port_done) begin
                    state_n = ST_GAP;
`ifdef PID_MASTER_OF_READ_EN
                    nxt_n   = ST_OF_RD;
`else
                    nxt_n   = ST_IDLE;
                    pub_n   = 1'b1;
`endif
                end
            end
`ifdef PID_MASTER_OF_READ_EN
            ST_OF_RD: begin
                req     = ~o_wb_cyc;
                req_idx = OF_IDX;
                if (port_done) begin
                    state_n = ST_GAP;
                    nxt_n   = ST_IDLE;
                    pub_n   = 1'b1;
                end
            end
`endif
            ST_RS_WR: begin
                req     = ~o_wb_cyc;
                req_we  = 1'b1;
                req_idx = RS_IDX;
                if (port_done) begin
                    state_n = ST_GAP;
                    nxt_n   = ST_IDLE;
                end
            end
            // Holds stb low for a cycle so the slave can release its ack.
            ST_GAP: state_n = nxt;
            default: state_n = ST_IDLE;
        endcase
        if (port_timeout) begin
            state_n      = ST_IDLE;
            err_n        = 1'b1;
            configured_n = 1'b0;
            pub_n        = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            nxt        <= ST_IDLE;
            cfg_cnt    <= 2'd0;
            configured <= 1'b0;
            pub        <= 1'b0;
            o_err      <= 1'b0;
            o_busy     <= 1'b0;
            o_pv_ready <= 1'b0;
            o_un       <= '0;
            o_un_valid <= 1'b0;
`ifdef PID_MASTER_OF_READ_EN
            o_of       <= '0;
            un_hold    <= '0;
`endif
        end else begin
            state      <= state_n;
            nxt        <= nxt_n;
            cfg_cnt    <= cfg_cnt_n;
            configured <= configured_n;
            pub        <= pub_n;
            o_err      <= err_n;
            o_busy     <= (state_n != ST_IDLE);
            o_pv_ready <= (state_n == ST_IDLE) && configured_n;
            o_un_valid <= (state == ST_GAP) && pub;
`ifdef PID_MASTER_OF_READ_EN
            if (state == ST_GAP && nxt == ST_OF_RD)
                un_hold <= rd_data;
            if (state == ST_GAP && pub) begin
                o_un <= un_hold;
                o_of <= rd_data[4:0];
            end
`else
            if (state == ST_GAP && pub)
                o_un <= rd_data;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (load_coef) begin
            coef[0] <= i_kp;
            coef[1] <= i_ki;
            coef[2] <= i_kd;
            coef[3] <= i_sp;
        end
        if (load_pv)
            pv_q <= i_pv;
    end

endmodule

// File: tb/tb_pid_wb_master.sv
// Bench for pid_wb_master: reactive Wishbone slave, transaction and u(n) scoreboards.
module tb_pid_wb_master;

`ifdef PID_MASTER_OF_READ_EN
    localparam int WB = 64;
    localparam int S  = 3;
`else
    localparam int WB = 32;
    localparam int S  = 2;
`endif
    localparam int AW = 16;
    localparam int TO = 20;

    logic                 clk, rst;
    logic                 cfg_start, clear, pv_valid, pv_ready;
    logic signed [15:0]   kp, ki, kd, sp, pv;
    logic                 wb_cyc, wb_stb, wb_we, wb_ack;
    logic [AW-1:0]        wb_adr;
    logic [WB-1:0]        wb_wdata, wb_rdata;
    logic [31:0]          un;
    logic                 un_valid, busy, err;
`ifdef PID_MASTER_OF_READ_EN
    logic [4:0]           of;
`endif

    pid_wb_master #(.wb_nb(WB), .adr_wb_nb(AW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_start(cfg_start),
        .i_kp(kp), .i_ki(ki), .i_kd(kd), .i_sp(sp),
        .i_clear(clear), .i_pv(pv), .i_pv_valid(pv_valid), .o_pv_ready(pv_ready),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_adr(wb_adr), .o_wb_data(wb_wdata),
        .i_wb_ack(wb_ack), .i_wb_data(wb_rdata),
        .o_un(un), .o_un_valid(un_valid), .o_busy(busy),
`ifdef PID_MASTER_OF_READ_EN
        .o_of(of),
`endif
        .o_err(err)
    );

    typedef struct {
        logic        we;
        logic [63:0] adr;
        logic [63:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] un_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    int          un_delay = 0;
    bit          noack = 0;
    int          wcnt = 0;
    int          low_cnt = 0;
    bit          saw_cyc = 0;
    int          pulses = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] adr_of(input int idx);
        return 64'(idx << S);
    endfunction

    function automatic logic [63:0] sext(input logic [15:0] v);
        logic [63:0] r;
        r = {{48{v[15]}}, v};
        if (WB == 32) r[63:32] = '0;
        return r;
    endfunction

    function automatic txn_t mk(input logic we, input int idx, input logic [15:0] v);
        txn_t t;
        t.we   = we;
        t.adr  = adr_of(idx);
        t.data = sext(v);
        return t;
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle++;

    // Slave model and output monitors, all acting on the falling edge.
    always @(negedge clk) begin
        int dly;
        txn_t t;
        if (wb_cyc) begin
            if (saw_cyc && low_cnt > 0) chk("gap", 64'(low_cnt >= 1), 1);
            saw_cyc = 1;
            low_cnt = 0;
        end else if (saw_cyc) begin
            low_cnt++;
        end
        if (rst || !wb_stb) begin
            wb_ack = 0;
            wcnt   = 0;
        end else if (!wb_ack) begin
            wcnt++;
            dly = (!wb_we && 64'(wb_adr) == adr_of(8)) ? un_delay : 0;
            if (!noack && wcnt > dly) begin
                wb_ack = 1;
                if (64'(wb_adr) == adr_of(8))       wb_rdata = WB'(32'h0000_1234);
                else if (64'(wb_adr) == adr_of(10)) wb_rdata = WB'(5);
                else                                wb_rdata = '0;
                chk("sb_has_exp", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    chk("txn_we", 64'(wb_we), 64'(t.we));
                    chk("txn_adr", 64'(wb_adr), t.adr);
                    if (t.we) chk("txn_data", 64'(wb_wdata), t.data);
                end
            end
        end
        if (un_valid) begin
            pulses++;
            chk("un_has_exp", 64'(un_q.size() != 0), 1);
            if (un_q.size() != 0) chk("un_val", 64'(un), 64'(un_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 400);
        chk(tag, 64'(busy), 0);
    endtask

    task automatic do_cfg();
        exp_q.push_back(mk(1, 0, kp));
        exp_q.push_back(mk(1, 1, ki));
        exp_q.push_back(mk(1, 2, kd));
        exp_q.push_back(mk(1, 3, sp));
        cfg_start = 1;
        tick(1);
        cfg_start = 0;
    endtask

    initial begin
        int n, t0, t1, p0;
        rst = 1; cfg_start = 0; clear = 0; pv_valid = 0; pv = 0;
        kp = 16'sh0010; ki = 16'sh0002; kd = -16'sd1; sp = 16'sh0100;
        wb_ack = 0; wb_rdata = '0;
        tick(3);
        chk("rst_cyc", 64'(wb_cyc), 0);
        chk("rst_stb", 64'(wb_stb), 0);
        chk("rst_we", 64'(wb_we), 0);
        chk("rst_adr", 64'(wb_adr), 0);
        chk("rst_data", 64'(wb_wdata), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready", 64'(pv_ready), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_un", 64'(un), 0);
        chk("rst_unv", 64'(un_valid), 0);
        rst = 0;
        tick(1);

        do_cfg();
        wait_idle("cfg_idle");
        tick(2);
        chk("cfg_ready", 64'(pv_ready), 1);
        chk("cfg_err", 64'(err), 0);
        chk("cfg_sb_empty", 64'(exp_q.size()), 0);

        un_delay = 9;
        p0 = pulses;
        pv = 16'sh00F0;
        exp_q.push_back(mk(1, 4, pv));
        exp_q.push_back(mk(0, 8, 16'h0));
`ifdef PID_MASTER_OF_READ_EN
        exp_q.push_back(mk(0, 10, 16'h0));
`endif
        un_q.push_back(32'h0000_1234);
        pv_valid = 1;
        tick(1);
        pv_valid = 0;
        wait_idle("pv_idle");
        tick(3);
        chk("pv_pulses", 64'(pulses - p0), 1);
        chk("pv_un", 64'(un), 64'h1234);
        chk("pv_err", 64'(err), 0);
        chk("pv_sb_empty", 64'(exp_q.size()), 0);
`ifdef PID_MASTER_OF_READ_EN
        chk("pv_of", 64'(of), 5);
`endif

        exp_q.push_back(mk(1, 11, 16'h0));
        pv = 16'sh0077;
        clear = 1;
        pv_valid = 1;
        tick(1);
        clear = 0;
        pv_valid = 0;
        wait_idle("rs_idle");
        tick(3);
        chk("rs_sb_empty", 64'(exp_q.size()), 0);
        chk("rs_ready", 64'(pv_ready), 1);

        exp_q.push_back(mk(1, 4, pv));
        exp_q.push_back(mk(0, 8, 16'h0));
        pv_valid = 1;
        tick(1);
        pv_valid = 0;
        n = 0;
        while (!(wb_cyc && !wb_we) && n < 200) begin
            tick(1);
            n++;
        end
        chk("rd_seen", 64'(wb_cyc && !wb_we), 1);
        rst = 1;
        tick(1);
        chk("mid_rst_cyc", 64'(wb_cyc), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_ready", 64'(pv_ready), 0);
        chk("mid_rst_un", 64'(un), 0);
        rst = 0;
        exp_q.delete();
        un_q.delete();
        tick(2);

        noack = 1;
        cfg_start = 1;
        tick(1);
        cfg_start = 0;
        n = 0;
        while (!wb_stb && n < 50) begin tick(1); n++; end
        chk("to_stb_up", 64'(wb_stb), 1);
        t0 = cycle;
        n = 0;
        while (wb_stb && n < 200) begin tick(1); n++; end
        t1 = cycle;
        chk("to_len", 64'(t1 - t0), 64'(TO));
        wait_idle("to_idle");
        tick(1);
        chk("to_err", 64'(err), 1);
        chk("to_ready", 64'(pv_ready), 0);
        noack = 0;
        do_cfg();
        tick(1);
        chk("to_err_clr", 64'(err), 0);
        wait_idle("re_cfg_idle");
        tick(2);
        chk("re_cfg_ready", 64'(pv_ready), 1);
        chk("re_cfg_sb_empty", 64'(exp_q.size()), 0);

        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
